// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input from EX, instruction-memory
// request/response channel, and decode-side instruction delivery.
//   master : the fetch unit (fetch_queue) -- drives imem_req/imem_addr and
//            the *_de outputs, samples redirect, stall and memory response.
//   slave  : the surrounding pipeline / memory -- the mirror image.
interface fetch_queue_if;
  logic        NextPCSrc;
  logic [31:0] Adress;
  logic        stall_de;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_de;
  logic [31:0] inst_de;
  logic [31:0] pc_de;
  logic [31:0] pcInc_de;

  modport master (
    input  NextPCSrc, Adress, stall_de, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, valid_de, inst_de, pc_de, pcInc_de
  );

  modport slave (
    output NextPCSrc, Adress, stall_de, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, valid_de, inst_de, pc_de, pcInc_de
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small instruction queue.
// Issues one instruction-memory request at a time from a fetch PC, queues
// {PC, instruction} responses and presents the queue head to decode.
// A redirect from EX flushes the queue, reloads the fetch PC and discards
// the response of any request still in flight.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   fq    - fetch_queue_if.master (redirect, imem request/response, decode)
// Parameters: RESET_PC (first fetch address), DEPTH (queue entries, 2..8,
// power of two).
// Optional macro FETCH_BYPASS_EN: a response arriving while the queue is
// empty is forwarded to decode in the same cycle.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_queue_if.master   fq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // IDLE: nothing in flight; WAIT: response pending and wanted;
  // DROP: response pending but stale after a redirect.
  typedef enum logic [1:0] {FS_IDLE, FS_WAIT, FS_DROP} fstate_t;

  fstate_t       state, state_nx;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic issue, accept, push, pop, empty, full;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. A response arriving together with a redirect still
  // retires the outstanding request, so no drop is needed afterwards.
  always_comb begin
    state_nx = state;
    unique case (state)
      FS_IDLE: if (issue) state_nx = FS_WAIT;
      FS_WAIT: begin
        if (fq.imem_rvalid)    state_nx = FS_IDLE;
        else if (fq.NextPCSrc) state_nx = FS_DROP;
      end
      FS_DROP: if (fq.imem_rvalid) state_nx = FS_IDLE;
      default: state_nx = FS_IDLE;
    endcase
  end

  // Output logic of the request FSM
  always_comb begin
    issue  = rst_n && (state == FS_IDLE) && !full && !fq.NextPCSrc;
    accept = (state == FS_WAIT) && fq.imem_rvalid && !fq.NextPCSrc;
  end

  assign fq.imem_req  = issue;
  assign fq.imem_addr = fetch_pc;

`ifdef FETCH_BYPASS_EN
  // A word forwarded straight to an accepting decode never enters the queue.
  logic bypass;
  assign bypass = empty && accept;
  assign push   = accept && !(bypass && !fq.stall_de);
`else
  assign push   = accept;
`endif
  assign pop = !fq.NextPCSrc && !fq.stall_de && !empty;

  // Fetch PC, request PC, queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (fq.NextPCSrc)  fetch_pc <= fq.Adress & 32'hFFFF_FFFC;
      else if (issue)    fetch_pc <= fetch_pc + 32'd4;
      if (issue)         req_pc   <= fetch_pc;

      if (fq.NextPCSrc) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end
  end

  // Queue storage needs no reset: occupancy qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[tail] <= fq.imem_rdata;
      q_pc[tail]   <= req_pc;
    end
  end

  // Decode-side outputs
  always_comb begin
    fq.valid_de = 1'b0;
    fq.inst_de  = NOP;
    fq.pc_de    = '0;
    fq.pcInc_de = '0;
    if (!empty) begin
      fq.valid_de = 1'b1;
      fq.inst_de  = q_inst[head];
      fq.pc_de    = q_pc[head];
      fq.pcInc_de = q_pc[head] + 32'd4;
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass) begin
      fq.valid_de = 1'b1;
      fq.inst_de  = fq.imem_rdata;
      fq.pc_de    = req_pc;
      fq.pcInc_de = req_pc + 32'd4;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned NCYC  = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fq   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, inst}, the fetch PC, and
  // whether a request is in flight / whether its answer is unwanted.
  logic [63:0] mq[$];
  logic [31:0] m_pc, m_req_pc;
  bit          m_out, m_drop;

  // Memory: one pending request answered after 1..3 cycles.
  bit          mem_busy;
  int unsigned mem_cnt;
  bit          stall_mode;

  function automatic void model_reset();
    mq.delete();
    m_pc     = RPC;
    m_req_pc = '0;
    m_out    = 1'b0;
    m_drop   = 1'b0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
  endfunction

  function automatic bit exp_req();
    return rst_n && !m_out && (mq.size() < DEPTH) && !bus.NextPCSrc;
  endfunction

  function automatic bit exp_bypass();
`ifdef FETCH_BYPASS_EN
    return (mq.size() == 0) && m_out && !m_drop && bus.imem_rvalid && !bus.NextPCSrc;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step();
    bit req, acc, byp;
    if (!rst_n) return;
    req = exp_req();
    byp = exp_bypass();
    acc = m_out && !m_drop && bus.imem_rvalid && !bus.NextPCSrc;
    if (m_out && bus.imem_rvalid) begin
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else if (m_out && bus.NextPCSrc) begin
      m_drop = 1'b1;
    end
    if (bus.NextPCSrc) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && !bus.stall_de) void'(mq.pop_front());
      if (acc && !(byp && !bus.stall_de)) mq.push_back({m_req_pc, bus.imem_rdata});
    end
    if (req) begin
      m_out    = 1'b1;
      m_req_pc = m_pc;
      m_pc     = m_pc + 32'd4;
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(1, 3);
    end
    if (bus.NextPCSrc) m_pc = {bus.Adress[31:2], 2'b00};
  endfunction

  task automatic drive(input int unsigned c);
    int unsigned sel;
    bus.NextPCSrc = ($urandom_range(0, 99) < 7);
    sel = $urandom_range(0, 3);
    case (sel)
      0: bus.Adress = 32'h0000_2003;
      1: bus.Adress = 32'hFFFF_FFFC;
      2: bus.Adress = 32'hFFFF_FFFE;
      default: bus.Adress = $urandom;
    endcase
    if ($urandom_range(0, 99) < 10) stall_mode = !stall_mode;
    bus.stall_de = stall_mode ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        mem_busy = 1'b0;
      end
    end else if ($urandom_range(0, 99) < 4) begin
      bus.imem_rvalid = 1'b1;   // unsolicited response
    end
    // Reset pulses mid-run; the release cycle carries a stale response.
    if (c == 700 || c == 2200) begin
      rst_n = 1'b0;
      model_reset();
    end
    if (c == 0 || c == 702 || c == 2202) begin
      rst_n = 1'b1;
      if (c != 0) bus.imem_rvalid = 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit          ev;
    logic [31:0] ei, ep;
    ev = 1'b0; ei = NOP; ep = '0;
    if (mq.size() != 0) begin
      ev = 1'b1; ei = mq[0][31:0]; ep = mq[0][63:32];
    end else if (exp_bypass()) begin
      ev = 1'b1; ei = bus.imem_rdata; ep = m_req_pc;
    end
    check("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req()});
    if (exp_req()) check("imem_addr", bus.imem_addr, m_pc);
    check("valid_de", {31'd0, bus.valid_de}, {31'd0, ev});
    check("inst_de",  bus.inst_de, ei);
    check("pc_de",    bus.pc_de, ep);
    check("pcInc_de", bus.pcInc_de, ev ? ep + 32'd4 : 32'd0);
  endtask

  initial begin
    bus.NextPCSrc   = 1'b0;
    bus.Adress      = '0;
    bus.stall_de    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    stall_mode      = 1'b0;
    model_reset();
    #2;
    check("reset_req",   {31'd0, bus.imem_req}, 32'd0);
    check("reset_valid", {31'd0, bus.valid_de}, 32'd0);
    check("reset_inst",  bus.inst_de, NOP);
    check("reset_pc",    bus.pc_de, 32'd0);
    check("reset_pcinc", bus.pcInc_de, 32'd0);
    @(posedge clk);
    for (int unsigned c = 0; c < NCYC; c++) begin
      #1;
      drive(c);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
